// File: rtl/npc_pkg.sv
// Shared types and sizing helpers for the next-PC unit.
package npc_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } npc_state_t;

  // Largest supported flush length and the counter width it needs
  localparam int unsigned NPC_FLUSH_MAX = 15;
  localparam int unsigned NPC_CNT_W     = $clog2(NPC_FLUSH_MAX + 1);

  // Flush counter width for a given flush length, $clog2(FLUSH_CYCLES+1), never below 1
  function automatic int unsigned npc_cnt_width(input int unsigned flush_cycles);
    int unsigned w;
    w = $clog2(flush_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/npc_target_calc.sv
// Combinational control-flow target, take and misalignment computation.
module npc_target_calc
  import npc_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALIGN_BITS = 2
) (
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_branch_en,
  input  logic            ex_taken,
  input  logic            ex_jal_en,
  input  logic            ex_jalr_en,
  output logic [XLEN-1:0] target,
  output logic            take,
  output logic            misalign
);

  logic [XLEN-1:0] pc_rel_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] align_mask;
  logic            pc_rel_sel;

  assign align_mask = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

  // PC-relative targets take precedence over JALR if several kinds are flagged
  always_comb begin
    pc_rel_sum = ex_pc + ex_imm;
    jalr_sum   = ex_rs1 + ex_imm;
    pc_rel_sel = (ex_branch_en & ex_taken) | ex_jal_en;
    target     = pc_rel_sel ? pc_rel_sum : {jalr_sum[XLEN-1:1], 1'b0};
    take       = ex_valid & (pc_rel_sel | ex_jalr_en);
    misalign   = take & (|(target & align_mask));
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC owner: sequential fetch, branch/jump/trap redirect with flush, misalign halt.
module next_pc_unit
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     INC          = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] fetch_addr,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_branch_en,
  input  logic            ex_taken,
  input  logic            ex_jal_en,
  input  logic            ex_jalr_en,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_vec,
  output logic            flush,
  output logic            redirect_en,
  output logic            misalign_err,
  output logic [XLEN-1:0] err_addr
);

  localparam int unsigned CNT_W = npc_cnt_width(FLUSH_CYCLES);

  npc_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            redirect_q, redirect_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] err_addr_q, err_addr_d;

  logic [XLEN-1:0] target;
  logic            take;
  logic            misalign;
  logic [XLEN-1:0] trap_tgt;
  logic            handshake;

  npc_target_calc #(
    .XLEN       (XLEN),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_target_calc (
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .ex_branch_en (ex_branch_en),
    .ex_taken     (ex_taken),
    .ex_jal_en    (ex_jal_en),
    .ex_jalr_en   (ex_jalr_en),
    .target       (target),
    .take         (take),
    .misalign     (misalign)
  );

  assign trap_tgt = {trap_vec[XLEN-1:1], 1'b0};

  // Next-state, PC, flush counter and pulse logic; priority trap > take > sequential
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    redirect_d  = 1'b0;
    misalign_d  = 1'b0;
    err_addr_d  = err_addr_q;
    fetch_valid = (state_q == RUN);
    flush       = (state_q == FLUSH);
    handshake   = fetch_valid & fetch_ready;

    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
      RUN, FLUSH: begin
        if (trap_en) begin
          state_d    = FLUSH;
          pc_d       = trap_tgt;
          cnt_d      = CNT_W'(FLUSH_CYCLES);
          redirect_d = 1'b1;
        end else if (take && misalign) begin
          state_d    = HALT;
          misalign_d = 1'b1;
          err_addr_d = target;
        end else if (take) begin
          state_d    = FLUSH;
          pc_d       = target;
          cnt_d      = CNT_W'(FLUSH_CYCLES);
          redirect_d = 1'b1;
        end else if (state_q == FLUSH) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) begin
            state_d = RUN;
          end
        end else if (handshake) begin
          pc_d = pc_q + XLEN'(INC);
        end
      end
      HALT: begin
        if (trap_en) begin
          state_d    = FLUSH;
          pc_d       = trap_tgt;
          cnt_d      = CNT_W'(FLUSH_CYCLES);
          redirect_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State, PC, counter and pulse registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      misalign_q <= misalign_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign fetch_addr   = pc_q;
  assign redirect_en  = redirect_q;
  assign misalign_err = misalign_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (4-byte and 2-byte alignment builds).
module tb_next_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        fetch_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_branch_en;
  logic        ex_taken;
  logic        ex_jal_en;
  logic        ex_jalr_en;
  logic        trap_en;
  logic [31:0] trap_vec;

  logic [31:0] fetch_addr, err_addr;
  logic        fetch_valid, flush, redirect_en, misalign_err;
  logic [31:0] d1_fetch_addr, d1_err_addr;
  logic        d1_fetch_valid, d1_flush, d1_redirect_en, d1_misalign_err;

  int unsigned n_checks;
  int unsigned n_fail;

  next_pc_unit #(
    .XLEN         (32),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2),
    .ALIGN_BITS   (2),
    .INC          (4)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .fetch_addr (fetch_addr), .fetch_valid (fetch_valid), .fetch_ready (fetch_ready),
    .ex_valid (ex_valid), .ex_pc (ex_pc), .ex_imm (ex_imm), .ex_rs1 (ex_rs1),
    .ex_branch_en (ex_branch_en), .ex_taken (ex_taken), .ex_jal_en (ex_jal_en),
    .ex_jalr_en (ex_jalr_en), .trap_en (trap_en), .trap_vec (trap_vec),
    .flush (flush), .redirect_en (redirect_en), .misalign_err (misalign_err),
    .err_addr (err_addr)
  );

  next_pc_unit #(
    .XLEN         (32),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2),
    .ALIGN_BITS   (1),
    .INC          (4)
  ) dut1 (
    .clk (clk), .reset_n (reset_n),
    .fetch_addr (d1_fetch_addr), .fetch_valid (d1_fetch_valid), .fetch_ready (fetch_ready),
    .ex_valid (ex_valid), .ex_pc (ex_pc), .ex_imm (ex_imm), .ex_rs1 (ex_rs1),
    .ex_branch_en (ex_branch_en), .ex_taken (ex_taken), .ex_jal_en (ex_jal_en),
    .ex_jalr_en (ex_jalr_en), .trap_en (trap_en), .trap_vec (trap_vec),
    .flush (d1_flush), .redirect_en (d1_redirect_en), .misalign_err (d1_misalign_err),
    .err_addr (d1_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid     = 1'b0;
    ex_pc        = '0;
    ex_imm       = '0;
    ex_rs1       = '0;
    ex_branch_en = 1'b0;
    ex_taken     = 1'b0;
    ex_jal_en    = 1'b0;
    ex_jalr_en   = 1'b0;
    trap_en      = 1'b0;
    trap_vec     = '0;
  endtask

  task automatic check_status(input string tag, input logic [31:0] addr, input logic valid,
                              input logic fl, input logic redir);
    check({tag, "_addr"},  fetch_addr, addr);
    check({tag, "_valid"}, {31'd0, fetch_valid}, {31'd0, valid});
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, "_redir"}, {31'd0, redirect_en}, {31'd0, redir});
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    fetch_ready = 1'b1;
    clear_ex();
    #1;
    check_status("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_err", err_addr, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    // Boot then sequential fetch
    tick(); check_status("boot", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check_status("seq4", 32'h4, 1'b1, 1'b0, 1'b0);
    tick(); check_status("seq8", 32'h8, 1'b1, 1'b0, 1'b0);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall_addr", fetch_addr, 32'h8);
    end

    // Taken backward branch, handshake in the same cycle is discarded
    fetch_ready  = 1'b1;
    ex_valid     = 1'b1; ex_branch_en = 1'b1; ex_taken = 1'b1;
    ex_pc        = 32'h100; ex_imm = 32'hFFFF_FFF0;
    tick(); clear_ex();
    check_status("br1", 32'hF0, 1'b0, 1'b1, 1'b1);
    fetch_ready = 1'b0;
    tick(); check_status("br2", 32'hF0, 1'b0, 1'b1, 1'b0);
    tick(); check_status("br3", 32'hF0, 1'b1, 1'b0, 1'b0);

    // JALR to 0x2002: misaligned for 4-byte build, legal for 2-byte build
    ex_valid = 1'b1; ex_jalr_en = 1'b1; ex_rs1 = 32'h2001; ex_imm = 32'h2;
    tick(); clear_ex();
    check_status("mis", 32'hF0, 1'b0, 1'b0, 1'b0);
    check("mis_pulse", {31'd0, misalign_err}, 32'd1);
    check("mis_err", err_addr, 32'h2002);
    check("a1_addr", d1_fetch_addr, 32'h2002);
    check("a1_redir", {31'd0, d1_redirect_en}, 32'd1);
    check("a1_mis", {31'd0, d1_misalign_err}, 32'd0);
    tick();
    check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);
    check("halt_valid", {31'd0, fetch_valid}, 32'd0);
    ex_valid = 1'b1; ex_jal_en = 1'b1; ex_pc = 32'h400; ex_imm = 32'h40;
    tick(); clear_ex();
    check_status("halt_ign", 32'hF0, 1'b0, 1'b0, 1'b0);
    check("halt_err_hold", err_addr, 32'h2002);

    // Trap exits HALT; bit 0 of trap_vec is cleared
    trap_en = 1'b1; trap_vec = 32'h801;
    tick(); clear_ex();
    check_status("trap1", 32'h800, 1'b0, 1'b1, 1'b1);
    tick();
    tick(); check_status("trap3", 32'h800, 1'b1, 1'b0, 1'b0);

    // Trap beats JAL, then JAL during flush restarts it
    trap_en = 1'b1; trap_vec = 32'h300;
    ex_valid = 1'b1; ex_jal_en = 1'b1; ex_pc = 32'h1000; ex_imm = 32'h20;
    tick(); clear_ex();
    check_status("tj", 32'h300, 1'b0, 1'b1, 1'b1);
    ex_valid = 1'b1; ex_jal_en = 1'b1; ex_pc = 32'h40; ex_imm = 32'h10;
    tick(); clear_ex();
    check_status("fj1", 32'h50, 1'b0, 1'b1, 1'b1);
    tick(); check_status("fj2", 32'h50, 1'b0, 1'b1, 1'b0);
    tick(); check_status("fj3", 32'h50, 1'b1, 1'b0, 1'b0);

    // Not-taken branch with handshake: plain sequential advance
    fetch_ready = 1'b1;
    ex_valid = 1'b1; ex_branch_en = 1'b1; ex_taken = 1'b0; ex_pc = 32'h200; ex_imm = 32'h40;
    tick(); clear_ex();
    check_status("nt", 32'h54, 1'b1, 1'b0, 1'b0);

    // Address wrap at the top of the space
    fetch_ready = 1'b0;
    ex_valid = 1'b1; ex_jal_en = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
    tick(); clear_ex();
    tick();
    tick(); check_status("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    fetch_ready = 1'b1;
    tick(); check_status("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a flush
    ex_valid = 1'b1; ex_jal_en = 1'b1; ex_pc = 32'h0; ex_imm = 32'h100;
    tick(); clear_ex();
    check_status("pre_rst", 32'h100, 1'b0, 1'b1, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_status("arst", 32'h0, 1'b0, 1'b0, 1'b0);
    check("arst_err", err_addr, 32'h0);
    tick();
    reset_n = 1'b1;
    tick(); check_status("reboot", 32'h0, 1'b1, 1'b0, 1'b0);
    tick(); check_status("reboot4", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
